// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Segment codes are active-high, packed as {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } state_t;

  localparam logic [15:0][6:0] SEG_CODES = {
    7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,  // F E D C
    7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,  // B A 9 8
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,  // 7 6 5 4
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111   // 3 2 1 0
  };

  localparam logic [6:0] DASH  = 7'b1000000;
  localparam logic [6:0] BLANK = 7'b0000000;

  function automatic logic [3:0] add3(input logic [3:0] i_bcd);
    return (i_bcd >= 4'd5) ? (i_bcd + 4'd3) : i_bcd;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; dash takes priority over blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  // Select dash, blank or the glyph for the digit
  always_comb begin
    o_seg = BLANK;
    if (i_dash) begin
      o_seg = DASH;
    end else if (i_blank) begin
      o_seg = BLANK;
    end else begin
      o_seg = SEG_CODES[i_digit];
    end
  end

endmodule

// File: rtl/display_bin_mult.sv
// Binary-to-display driver: sequential double-dabble or direct hex digits,
// latched into a display register and scanned over DIGITS multiplexed digits.
module display_bin_mult
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 9,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entrada_valid,
  input  logic [WIDTH-1:0]  entradaBin,
  input  logic              modo_hex,
  input  logic              blank_zeros,
  output logic              entrada_ready,
  output logic [DIGITS-1:0] digit_sel,
  output logic [6:0]        outputSegmentos,
  output logic              overflow
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int EXT_W  = (WIDTH > BCD_W) ? WIDTH : BCD_W;
  localparam int IT_W   = $clog2(WIDTH + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t             r_state;
  logic               r_ready;
  logic [WIDTH-1:0]   r_value;
  logic               r_hex;
  logic               r_blank;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_bcd_ovf;
  logic [IT_W-1:0]    r_iter;
  logic [BCD_W-1:0]   r_disp;
  logic [DIGITS-1:0]  r_disp_blank;
  logic               r_ovf;
  logic [SCAN_W-1:0]  r_scan;
  logic [IDX_W-1:0]   r_idx;
  logic [DIGITS-1:0]  r_sel;
  logic [6:0]         r_seg;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_next;
  logic               w_carry;
  logic [EXT_W-1:0]   w_ext;
  logic [BCD_W-1:0]   w_new_dig;
  logic               w_new_ovf;
  logic [DIGITS-1:0]  w_new_blank;
  logic               w_lead;
  logic [3:0]         w_cur_dig;
  logic               w_cur_blank;
  logic [6:0]         w_seg;

  // One double-dabble step; a bit carried out of the top digit means the value cannot fit
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      w_adj[4*k +: 4] = add3(r_bcd[4*k +: 4]);
    end
    {w_carry, w_bcd_next} = {w_adj, r_value[WIDTH-1]};
  end

  // Next display content, overflow flag and leading-zero mask
  always_comb begin
    w_ext       = EXT_W'(r_value);
    w_new_blank = '0;
    w_lead      = 1'b1;
    if (r_hex) begin
      w_new_dig = w_ext[BCD_W-1:0];
      w_new_ovf = |(w_ext >> BCD_W);
    end else begin
      w_new_dig = r_bcd;
      w_new_ovf = r_bcd_ovf;
    end
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_lead         = w_lead & (w_new_dig[4*k +: 4] == 4'd0);
      w_new_blank[k] = w_lead & r_blank & ~w_new_ovf;
    end
  end

  // Accept / convert / update sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= OCIOSO;
      r_ready      <= 1'b1;
      r_value      <= '0;
      r_hex        <= 1'b0;
      r_blank      <= 1'b0;
      r_bcd        <= '0;
      r_bcd_ovf    <= 1'b0;
      r_iter       <= '0;
      r_disp       <= '0;
      r_disp_blank <= {DIGITS{1'b1}} << 1;
      r_ovf        <= 1'b0;
    end else begin
      case (r_state)
        OCIOSO: begin
          if (entrada_valid) begin
            r_value   <= entradaBin;
            r_hex     <= modo_hex;
            r_blank   <= blank_zeros;
            r_bcd     <= '0;
            r_bcd_ovf <= 1'b0;
            r_iter    <= '0;
            r_ready   <= 1'b0;
            r_state   <= modo_hex ? ATUALIZA : CONVERTE;
          end
        end
        CONVERTE: begin
          r_bcd     <= w_bcd_next;
          r_bcd_ovf <= r_bcd_ovf | w_carry;
          r_value   <= {r_value[WIDTH-2:0], 1'b0};
          r_iter    <= r_iter + IT_W'(1);
          if (r_iter == IT_W'(WIDTH - 1)) begin
            r_state <= ATUALIZA;
          end
        end
        ATUALIZA: begin
          r_disp       <= w_new_dig;
          r_disp_blank <= w_new_blank;
          r_ovf        <= w_new_ovf;
          r_ready      <= 1'b1;
          r_state      <= OCIOSO;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= OCIOSO;
        end
      endcase
    end
  end

  assign w_cur_dig   = r_disp[4*r_idx +: 4];
  assign w_cur_blank = r_disp_blank[r_idx];

  seg7_decode u_decode (
    .i_digit (w_cur_dig),
    .i_blank (w_cur_blank),
    .i_dash  (r_ovf),
    .o_seg   (w_seg)
  );

  // Digit scanning; select and segments are registered together so they never disagree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_sel  <= DIGITS'(1);
      r_seg  <= SEG_CODES[0];
    end else begin
      if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan <= '0;
        r_idx  <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : (r_idx + IDX_W'(1));
      end else begin
        r_scan <= r_scan + SCAN_W'(1);
      end
      r_sel <= DIGITS'(1) << r_idx;
      r_seg <= w_seg;
    end
  end

  assign entrada_ready   = r_ready;
  assign digit_sel       = r_sel;
  assign outputSegmentos = r_seg;
  assign overflow        = r_ovf;

endmodule

// File: tb/tb_display_bin_mult.sv
// Directed bench: 3-digit and 2-digit instances, hand-computed segment patterns.
module tb_display_bin_mult;

  localparam logic [6:0] S0 = 7'b0111111, S2 = 7'b1011011, S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101, S7 = 7'b0000111, S9 = 7'b1101111;
  localparam logic [6:0] SA = 7'b1110111, SF = 7'b1110001;
  localparam logic [6:0] SD = 7'b1000000, SB = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 1'b0, hex = 1'b0, blank = 1'b0;
  logic [8:0] bin = 9'd0;
  logic       ready, ovf;
  logic [2:0] sel;
  logic [6:0] seg;
  logic       v2 = 1'b0, hex2 = 1'b0, blank2 = 1'b0;
  logic [8:0] bin2 = 9'd0;
  logic       ready2, ovf2;
  logic [1:0] sel2;
  logic [6:0] seg2;

  int errors = 0;
  int checks = 0;
  logic [6:0] d0, d1, d2;

  always #5 clk = ~clk;

  display_bin_mult #(.DIGITS(3), .WIDTH(9), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .entrada_valid(v), .entradaBin(bin), .modo_hex(hex),
    .blank_zeros(blank), .entrada_ready(ready), .digit_sel(sel),
    .outputSegmentos(seg), .overflow(ovf)
  );

  display_bin_mult #(.DIGITS(2), .WIDTH(9), .SCAN_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .entrada_valid(v2), .entradaBin(bin2), .modo_hex(hex2),
    .blank_zeros(blank2), .entrada_ready(ready2), .digit_sel(sel2),
    .outputSegmentos(seg2), .overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [8:0] b, input logic h, input logic bl);
    @(negedge clk);
    check("offer_ready", 32'(ready), 32'd1);
    bin = b; hex = h; blank = bl; v = 1'b1;
    @(negedge clk);
    v = 1'b0;
  endtask

  task automatic offer2(input logic [8:0] b, input logic h, input logic bl);
    @(negedge clk);
    check("offer2_ready", 32'(ready2), 32'd1);
    bin2 = b; hex2 = h; blank2 = bl; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
  endtask

  task automatic cap3(output logic [6:0] c0, output logic [6:0] c1, output logic [6:0] c2);
    logic [2:0] seen;
    logic       oh_ok;
    seen = 3'b000; oh_ok = 1'b1;
    c0 = 'x; c1 = 'x; c2 = 'x;
    for (int i = 0; i < 24 && seen != 3'b111; i++) begin
      @(negedge clk);
      if (!$onehot(sel)) oh_ok = 1'b0;
      case (sel)
        3'b001:  begin c0 = seg; seen[0] = 1'b1; end
        3'b010:  begin c1 = seg; seen[1] = 1'b1; end
        3'b100:  begin c2 = seg; seen[2] = 1'b1; end
        default: ;
      endcase
    end
    check("cap3_seen", 32'(seen), 32'h7);
    check("cap3_onehot", 32'(oh_ok), 32'd1);
  endtask

  task automatic cap2(output logic [6:0] c0, output logic [6:0] c1);
    logic [1:0] seen;
    seen = 2'b00;
    c0 = 'x; c1 = 'x;
    for (int i = 0; i < 20 && seen != 2'b11; i++) begin
      @(negedge clk);
      case (sel2)
        2'b01:   begin c0 = seg2; seen[0] = 1'b1; end
        2'b10:   begin c1 = seg2; seen[1] = 1'b1; end
        default: ;
      endcase
    end
    check("cap2_seen", 32'(seen), 32'h3);
  endtask

  initial begin
    logic [2:0] exp_sel;
    int len;

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_sel", 32'(sel), 32'h1);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_seg", 32'(seg), 32'(S0));
    rst = 1'b0;
    cap3(d0, d1, d2);
    check("rst_d0", 32'(d0), 32'(S0));
    check("rst_d1", 32'(d1), 32'(SB));
    check("rst_d2", 32'(d2), 32'(SB));

    // Scan sequence 001 -> 010 -> 100 -> 001, 4 cycles each
    for (int i = 0; i < 20 && sel != 3'b010; i++) @(negedge clk);
    exp_sel = 3'b010;
    for (int s = 0; s < 3; s++) begin
      check("scan_sel", 32'(sel), 32'(exp_sel));
      len = 0;
      while (sel == exp_sel && len < 10) begin
        @(negedge clk);
        len++;
      end
      check("scan_len", 32'(len), 32'd4);
      exp_sel = {exp_sel[1:0], exp_sel[2]};
    end

    // Decimal 255, blank off: ready returns right after edge N+10
    offer(9'd255, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    check("dec255_busy", 32'(ready), 32'd0);
    @(negedge clk);
    check("dec255_ready", 32'(ready), 32'd1);
    cap3(d0, d1, d2);
    check("dec255_d0", 32'(d0), 32'(S5));
    check("dec255_d1", 32'(d1), 32'(S5));
    check("dec255_d2", 32'(d2), 32'(S2));
    check("dec255_ovf", 32'(ovf), 32'd0);

    // Decimal 7 and 0 with leading-zero blanking
    offer(9'd7, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    cap3(d0, d1, d2);
    check("dec7_d0", 32'(d0), 32'(S7));
    check("dec7_d1", 32'(d1), 32'(SB));
    check("dec7_d2", 32'(d2), 32'(SB));
    offer(9'd0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    cap3(d0, d1, d2);
    check("dec0_d0", 32'(d0), 32'(S0));
    check("dec0_d1", 32'(d1), 32'(SB));
    check("dec0_d2", 32'(d2), 32'(SB));

    // Hex 0x0AF, blank off: one-cycle update
    offer(9'h0AF, 1'b1, 1'b0);
    check("hex_busy", 32'(ready), 32'd0);
    @(negedge clk);
    check("hex_ready", 32'(ready), 32'd1);
    cap3(d0, d1, d2);
    check("hex_d0", 32'(d0), 32'(SF));
    check("hex_d1", 32'(d1), 32'(SA));
    check("hex_d2", 32'(d2), 32'(S0));
    check("hex_ovf", 32'(ovf), 32'd0);

    // Two-digit instance: decimal overflow, recovery, hex overflow with blanking ignored
    offer2(9'd100, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    cap2(d0, d1);
    check("d2_100_d0", 32'(d0), 32'(SD));
    check("d2_100_d1", 32'(d1), 32'(SD));
    check("d2_100_ovf", 32'(ovf2), 32'd1);
    offer2(9'd99, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    cap2(d0, d1);
    check("d2_99_d0", 32'(d0), 32'(S9));
    check("d2_99_d1", 32'(d1), 32'(S9));
    check("d2_99_ovf", 32'(ovf2), 32'd0);
    offer2(9'h1AF, 1'b1, 1'b1);
    @(negedge clk);
    cap2(d0, d1);
    check("d2_hex_d0", 32'(d0), 32'(SD));
    check("d2_hex_d1", 32'(d1), 32'(SD));
    check("d2_hex_ovf", 32'(ovf2), 32'd1);

    // Valid held through a conversion: 45 is taken only once ready returns
    @(negedge clk);
    bin = 9'd123; hex = 1'b0; blank = 1'b0; v = 1'b1;
    @(negedge clk);
    bin = 9'd45;
    repeat (9) @(negedge clk);
    check("hold_busy", 32'(ready), 32'd0);
    @(negedge clk);
    check("hold_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("hold_second_accept", 32'(ready), 32'd0);
    v = 1'b0;
    repeat (9) @(negedge clk);
    check("hold_busy2", 32'(ready), 32'd0);
    @(negedge clk);
    check("hold_ready2", 32'(ready), 32'd1);
    cap3(d0, d1, d2);
    check("hold_d0", 32'(d0), 32'(S5));
    check("hold_d1", 32'(d1), 32'(S4));
    check("hold_d2", 32'(d2), 32'(S0));

    // Reset in cycle 5 of a conversion of 321
    offer(9'd321, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_sel", 32'(sel), 32'h1);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_seg", 32'(seg), 32'(S0));
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_idle", 32'(ready), 32'd1);
    cap3(d0, d1, d2);
    check("abort_d0", 32'(d0), 32'(S0));
    check("abort_d1", 32'(d1), 32'(SB));
    check("abort_d2", 32'(d2), 32'(SB));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
